// File: rtl/mips16_pkg.sv
// Shared constants and types for the mips16 decode/forwarding slice.
// Stage records describe one in-flight instruction as seen by forwarding.
package mips16_pkg;

    localparam int DW           = 16;
    localparam int AW           = 5;
    localparam int SINK_REG_DEF = 31;

    // Operand mux source select, numbered by producer age (1 = youngest).
    typedef enum logic [1:0] {
        SEL_REG = 2'b00,
        SEL_EX  = 2'b01,
        SEL_DM  = 2'b10,
        SEL_WB  = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic [AW-1:0] dst;
        logic          wr;
        logic          ld;
    } stage_t;

    localparam stage_t BUBBLE = '{dst: '0, wr: 1'b0, ld: 1'b0};

endpackage

// File: rtl/fwd_sel_compare.sv
// Picks the forwarding source for one operand from the three older stages.
// Optional ZERO_REG_EN: source register 0 never forwards.
module fwd_sel_compare
    import mips16_pkg::*;
#(
    parameter int AW = mips16_pkg::AW
) (
    input  logic [AW-1:0] src,
    input  stage_t        s1,
    input  stage_t        s2,
    input  stage_t        s3,
    output logic [1:0]    sel
);

    // Youngest producer wins, so the chain tests s1 first.
    always_comb begin
        sel = SEL_REG;
        if (s1.wr && (s1.dst == src)) begin
            sel = SEL_EX;
        end else if (s2.wr && (s2.dst == src)) begin
            sel = SEL_DM;
        end else if (s3.wr && (s3.dst == src)) begin
            sel = SEL_WB;
        end
`ifdef ZERO_REG_EN
        if (src == '0) begin
            sel = SEL_REG;
        end
`endif
    end

endmodule

// File: rtl/operand_forward_unit.sv
// Decode-side forwarding/hazard control feeding Register_Bank_Block.
// Optional ZERO_REG_EN: R0 is hardwired zero (never written, forwarded or stalled on).
module operand_forward_unit
    import mips16_pkg::*;
#(
    parameter int DW       = mips16_pkg::DW,
    parameter int AW       = mips16_pkg::AW,
    parameter int SINK_REG = mips16_pkg::SINK_REG_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [AW-1:0] src_a,
    input  logic [AW-1:0] src_b,
    input  logic [AW-1:0] dst,
    input  logic          wr_reg,
    input  logic          is_load,
    input  logic          use_imm,
    input  logic [DW-1:0] imm_in,
    output logic          stall,
    output logic [AW-1:0] RA,
    output logic [AW-1:0] RB,
    output logic [1:0]    mux_sel_A,
    output logic [1:0]    mux_sel_B,
    output logic [DW-1:0] imm,
    output logic          imm_sel,
    output logic [AW-1:0] RW_dm
);

    localparam logic [AW-1:0] SINK_ADDR = AW'(SINK_REG);

    stage_t     s1, s2, s3;
    logic [1:0] sel_a_next, sel_b_next;
    logic       id_wr;
    logic       issue;

`ifdef ZERO_REG_EN
    assign id_wr = wr_reg && (dst != '0);
`else
    assign id_wr = wr_reg;
`endif

    assign RA    = src_a;
    assign RB    = src_b;
    assign RW_dm = s3.wr ? s3.dst : SINK_ADDR;
    assign issue = in_valid && !stall;

    // A load in s1 cannot be forwarded yet; a consumer must wait one cycle.
    always_comb begin
        stall = 1'b0;
        if (in_valid && s1.wr && s1.ld) begin
            if ((src_a == s1.dst) || (!use_imm && (src_b == s1.dst))) begin
                stall = 1'b1;
            end
        end
    end

    fwd_sel_compare #(.AW(AW)) u_sel_a (
        .src (src_a),
        .s1  (s1),
        .s2  (s2),
        .s3  (s3),
        .sel (sel_a_next)
    );

    fwd_sel_compare #(.AW(AW)) u_sel_b (
        .src (src_b),
        .s1  (s1),
        .s2  (s2),
        .s3  (s3),
        .sel (sel_b_next)
    );

    // Selects and immediate are registered so they line up with the bank's AR/BR in EX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1        <= BUBBLE;
            s2        <= BUBBLE;
            s3        <= BUBBLE;
            mux_sel_A <= SEL_REG;
            mux_sel_B <= SEL_REG;
            imm       <= '0;
            imm_sel   <= 1'b0;
        end else begin
            s3 <= s2;
            s2 <= s1;
            if (issue) begin
                s1        <= '{dst: dst, wr: id_wr, ld: is_load};
                mux_sel_A <= sel_a_next;
                mux_sel_B <= sel_b_next;
                imm       <= imm_in;
                imm_sel   <= use_imm;
            end else begin
                s1        <= BUBBLE;
                mux_sel_A <= SEL_REG;
                mux_sel_B <= SEL_REG;
                imm       <= '0;
                imm_sel   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_forward_unit.sv
// Self-checking bench for operand_forward_unit: directed literal checks plus
// randomized traffic compared every cycle against an age-based history model.
module tb_operand_forward_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [4:0]  src_a, src_b, dst;
   logic        wr_reg, is_load, use_imm;
   logic [15:0] imm_in;
   logic        stall;
   logic [4:0]  RA, RB, RW_dm;
   logic [1:0]  mux_sel_A, mux_sel_B;
   logic [15:0] imm;
   logic        imm_sel;

   int checks = 0;
   int errors = 0;

   // History model: entry k is what entered the pipeline k edges ago.
   logic [4:0]  hdst [1:3];
   logic        hwr  [1:3];
   logic        hld  [1:3];
   logic [1:0]  exp_sel_a, exp_sel_b;
   logic [15:0] exp_imm;
   logic        exp_imm_sel;
   logic        model_ready = 1'b0;
   logic        last_stalled = 1'b0;
   logic        stall_seen;

   logic        r_rst, r_v, r_w, r_l, r_u;
   logic [4:0]  r_a, r_b, r_d;
   logic [15:0] r_im;

   operand_forward_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .src_a     (src_a),
      .src_b     (src_b),
      .dst       (dst),
      .wr_reg    (wr_reg),
      .is_load   (is_load),
      .use_imm   (use_imm),
      .imm_in    (imm_in),
      .stall     (stall),
      .RA        (RA),
      .RB        (RB),
      .mux_sel_A (mux_sel_A),
      .mux_sel_B (mux_sel_B),
      .imm       (imm),
      .imm_sel   (imm_sel),
      .RW_dm     (RW_dm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The select is simply the age of the youngest in-flight writer of src.
   function automatic logic [1:0] modelSel(input logic [4:0] src);
      logic [1:0] r;
      r = 2'b00;
      for (int k = 3; k >= 1; k--) begin
         if (hwr[k] && (hdst[k] == src)) r = 2'(k);
      end
`ifdef ZERO_REG_EN
      if (src == 5'd0) r = 2'b00;
`endif
      return r;
   endfunction

   function automatic logic modelStall();
      return in_valid && hwr[1] && hld[1] &&
             ((src_a == hdst[1]) || (!use_imm && (src_b == hdst[1])));
   endfunction

   function automatic logic [4:0] modelRw();
      return hwr[3] ? hdst[3] : 5'd31;
   endfunction

   task automatic modelEdge();
      logic       go;
      logic [1:0] a, b;
      if (!rst_n) begin
         for (int k = 1; k <= 3; k++) begin
            hdst[k] = 5'd0;
            hwr[k]  = 1'b0;
            hld[k]  = 1'b0;
         end
         exp_sel_a    = 2'b00;
         exp_sel_b    = 2'b00;
         exp_imm      = 16'h0;
         exp_imm_sel  = 1'b0;
         last_stalled = 1'b0;
         model_ready  = 1'b1;
      end else begin
         last_stalled = modelStall();
         go = in_valid && !last_stalled;
         a  = modelSel(src_a);
         b  = modelSel(src_b);
         for (int k = 3; k >= 2; k--) begin
            hdst[k] = hdst[k-1];
            hwr[k]  = hwr[k-1];
            hld[k]  = hld[k-1];
         end
         hdst[1] = dst;
`ifdef ZERO_REG_EN
         hwr[1]  = go && wr_reg && (dst != 5'd0);
`else
         hwr[1]  = go && wr_reg;
`endif
         hld[1]      = go && is_load;
         exp_sel_a   = go ? a : 2'b00;
         exp_sel_b   = go ? b : 2'b00;
         exp_imm     = go ? imm_in : 16'h0;
         exp_imm_sel = go ? use_imm : 1'b0;
      end
   endtask

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic v, input logic [4:0] a,
                                input logic [4:0] b, input logic [4:0] d, input logic w,
                                input logic l, input logic u, input logic [15:0] im);
      rst_n    = r;
      in_valid = v;
      src_a    = a;
      src_b    = b;
      dst      = d;
      wr_reg   = w;
      is_load  = l;
      use_imm  = u;
      imm_in   = im;
      #1 stall_seen = stall;
      @(posedge clk);
      #1 modelEdge();
   endtask

   task automatic issueOp(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                          input logic w, input logic l, input logic u, input logic [15:0] im);
      applyStimulus(1'b1, 1'b1, a, b, d, w, l, u, im);
   endtask

   task automatic nop();
      applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic flush();
      repeat (3) nop();
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (model_ready && rst_n) begin
            checkOutput("stall",     16'(stall),     16'(modelStall()));
            checkOutput("RA",        16'(RA),        16'(src_a));
            checkOutput("RB",        16'(RB),        16'(src_b));
            checkOutput("RW_dm",     16'(RW_dm),     16'(modelRw()));
            checkOutput("mux_sel_A", 16'(mux_sel_A), 16'(exp_sel_a));
            checkOutput("mux_sel_B", 16'(mux_sel_B), 16'(exp_sel_b));
            checkOutput("imm",       imm,            exp_imm);
            checkOutput("imm_sel",   16'(imm_sel),   16'(exp_imm_sel));
         end
      end
   end

   initial begin
      applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0);
      applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0);
      checkOutput("reset_RW_dm",   16'(RW_dm),     16'd31);
      checkOutput("reset_sel_A",   16'(mux_sel_A), 16'd0);
      checkOutput("reset_imm_sel", 16'(imm_sel),   16'd0);

      for (int i = 0; i < 10; i++) begin
         nop();
         checkOutput("idle_RW_dm", 16'(RW_dm), 16'd31);
         checkOutput("idle_stall", 16'(stall_seen), 16'd0);
      end

      for (int g = 0; g < 4; g++) begin
         flush();
         issueOp(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 16'h0);
         repeat (g) nop();
         issueOp(5'd3, 5'd5, 5'd20, 1'b1, 1'b0, 1'b0, 16'h0);
         checkOutput("fwd_gap_A", 16'(mux_sel_A), (g == 3) ? 16'd0 : 16'(g + 1));
      end

      flush();
      issueOp(5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 16'h0);
      issueOp(5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 16'h0);
      issueOp(5'd9, 5'd4, 5'd10, 1'b1, 1'b0, 1'b0, 16'h0);
      checkOutput("double_match_B", 16'(mux_sel_B), 16'd1);

      flush();
      issueOp(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 16'h0);
      issueOp(5'd7, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 16'h0);
      checkOutput("load_use_stall", 16'(stall_seen), 16'd1);
      checkOutput("load_use_bubble", 16'(mux_sel_A), 16'd0);
      issueOp(5'd7, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 16'h0);
      checkOutput("load_use_restall", 16'(stall_seen), 16'd0);
      checkOutput("load_use_sel_A", 16'(mux_sel_A), 16'd2);

      flush();
      issueOp(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 16'h0);
      issueOp(5'd1, 5'd7, 5'd9, 1'b1, 1'b0, 1'b1, 16'hBEEF);
      checkOutput("imm_no_stall", 16'(stall_seen), 16'd0);
      checkOutput("imm_value", imm, 16'hBEEF);
      checkOutput("imm_sel_set", 16'(imm_sel), 16'd1);
      checkOutput("imm_sel_B", 16'(mux_sel_B), 16'd1);
      nop();
      checkOutput("imm_cleared", imm, 16'h0);

      flush();
      issueOp(5'd1, 5'd2, 5'd12, 1'b1, 1'b0, 1'b0, 16'h0);
      nop();
      checkOutput("rw_early", 16'(RW_dm), 16'd31);
      nop();
      checkOutput("rw_track", 16'(RW_dm), 16'd12);

      flush();
      issueOp(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 16'h0);
      issueOp(5'd0, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0, 16'h0);
`ifdef ZERO_REG_EN
      checkOutput("zero_sel_A", 16'(mux_sel_A), 16'd0);
      nop();
      checkOutput("zero_rw", 16'(RW_dm), 16'd31);
`else
      checkOutput("zero_sel_A", 16'(mux_sel_A), 16'd1);
      nop();
      checkOutput("zero_rw", 16'(RW_dm), 16'd0);
`endif

      // Random traffic over a small register set to provoke frequent hazards.
      for (int i = 0; i < 3000; i++) begin
         if (!last_stalled) begin
            r_a  = 5'($urandom_range(0, 7));
            r_b  = 5'($urandom_range(0, 7));
            r_d  = 5'($urandom_range(0, 7));
            r_v  = ($urandom_range(0, 3) != 0);
            r_w  = ($urandom_range(0, 3) != 0);
            r_l  = ($urandom_range(0, 2) == 0);
            r_u  = ($urandom_range(0, 2) == 0);
            r_im = 16'($urandom);
         end
         r_rst = ($urandom_range(0, 99) != 0);
         applyStimulus(r_rst, r_v, r_a, r_b, r_d, r_w, r_l, r_u, r_im);
      end

      nop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
